// File: rtl/bomb_placer.sv
// Place-bomb write port: turns player button edges into single-cell writes of state 1 into the bomb map,
// enforcing play-area bounds, per-player slot capacity, cooldown and one write per cycle.
module bomb_placer #(
    parameter int MAX_BOMBS = 2,
    parameter int COOLDOWN  = 25000000,
    parameter int CD_W      = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btnA,
    input  logic         btnB,
    input  logic [3:0]   playerAx,
    input  logic [3:0]   playerAy,
    input  logic [3:0]   playerBx,
    input  logic [3:0]   playerBy,
    input  logic [199:0] i_curBombMap,
    input  logic [1:0]   game_state,
    output logic         o_wrEn,
    output logic [6:0]   o_wrIdx,
    output logic [1:0]   o_wrVal,
    output logic         o_reject,
    output logic [1:0]   o_activeA,
    output logic [1:0]   o_activeB
);

    function automatic logic cellEmpty(input logic [199:0] map, input logic [6:0] idx);
        logic empty;
        int   base;
        empty = 1'b0;
        base  = 2 * int'(idx);
        if (idx < 7'd100) begin
            empty = (map[base +: 2] == 2'd0);
        end else begin
            empty = 1'b0;
        end
        return empty;
    endfunction

    function automatic logic [6:0] cellIndex(input logic [3:0] x, input logic [3:0] y);
        return ({3'b000, x} * 7'd10) + {3'b000, y};
    endfunction

    function automatic logic [1:0] popCount(input logic [MAX_BOMBS-1:0] v);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < MAX_BOMBS; i++) begin
            n = n + {1'b0, v[i]};
        end
        return n;
    endfunction

    // index 0 is player A, index 1 is player B
    logic [1:0]           prev_r;
    logic [1:0]           pend_r;
    logic [CD_W-1:0]      cd_r      [2];
    logic [MAX_BOMBS-1:0] valid_r   [2];
    logic [MAX_BOMBS-1:0] fresh_r   [2];
    logic [6:0]           idx_r     [2][MAX_BOMBS];
    logic                 lastServed_r;

    logic [1:0]           btn_s;
    logic [1:0]           rise_s;
    logic [3:0]           px_s      [2];
    logic [3:0]           py_s      [2];
    logic                 running_s;
    logic                 both_s;
    logic                 grant_s;
    logic                 anyGrant_s;
    logic [6:0]           gIdx_s;
    logic                 inRange_s;
    logic                 hasFree_s;
    logic                 notPrev_s;
    logic                 pass_s;
    logic                 taken_s;
    logic [1:0]           pendNext_s;
    logic [CD_W-1:0]      cdNext_s  [2];
    logic [MAX_BOMBS-1:0] relValid_s[2];
    logic [MAX_BOMBS-1:0] validNext_s[2];
    logic [MAX_BOMBS-1:0] freshNext_s[2];
    logic [6:0]           idxNext_s [2][MAX_BOMBS];
    logic                 lastServedNext_s;

    // Slot release, arbitration, validation and next-state computation
    always_comb begin
        btn_s            = {btnB, btnA};
        px_s[0]          = playerAx;
        py_s[0]          = playerAy;
        px_s[1]          = playerBx;
        py_s[1]          = playerBy;
        rise_s           = btn_s & ~prev_r;
        running_s        = (game_state == 2'd0);
        both_s           = pend_r[0] & pend_r[1];
        anyGrant_s       = running_s & (|pend_r);
        lastServedNext_s = lastServed_r;
        hasFree_s        = 1'b0;
        taken_s          = 1'b0;

        // lastServed_r high means A won the last contention, so B goes first next time
        if (both_s) begin
            grant_s = lastServed_r;
        end else if (pend_r[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end

        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < MAX_BOMBS; s++) begin
                relValid_s[p][s] = valid_r[p][s] & (fresh_r[p][s] | ~cellEmpty(i_curBombMap, idx_r[p][s]));
                idxNext_s[p][s]  = idx_r[p][s];
            end
            validNext_s[p] = relValid_s[p];
            freshNext_s[p] = '0;
        end

        gIdx_s    = cellIndex(px_s[grant_s], py_s[grant_s]);
        inRange_s = (px_s[grant_s] >= 4'd1) && (px_s[grant_s] <= 4'd8) &&
                    (py_s[grant_s] >= 4'd1) && (py_s[grant_s] <= 4'd8);
        for (int s = 0; s < MAX_BOMBS; s++) begin
            hasFree_s = hasFree_s | ~relValid_s[grant_s][s];
        end
        // The map write issued last cycle is not yet visible in i_curBombMap
        notPrev_s = ~(o_wrEn && (o_wrIdx == gIdx_s));
        pass_s    = anyGrant_s & inRange_s & cellEmpty(i_curBombMap, gIdx_s) & notPrev_s & hasFree_s;

        for (int s = 0; s < MAX_BOMBS; s++) begin
            if (pass_s && !taken_s && !relValid_s[grant_s][s]) begin
                taken_s                     = 1'b1;
                validNext_s[grant_s][s]     = 1'b1;
                freshNext_s[grant_s][s]     = 1'b1;
                idxNext_s[grant_s][s]       = gIdx_s;
            end else begin
                taken_s = taken_s;
            end
        end

        for (int p = 0; p < 2; p++) begin
            if (!running_s) begin
                pendNext_s[p] = 1'b0;
            end else if (anyGrant_s && (int'(grant_s) == p)) begin
                pendNext_s[p] = 1'b0;
            end else if (rise_s[p] && (cd_r[p] == '0)) begin
                pendNext_s[p] = 1'b1;
            end else begin
                pendNext_s[p] = pend_r[p];
            end

            if (pass_s && (int'(grant_s) == p)) begin
                cdNext_s[p] = CD_W'(COOLDOWN);
            end else if (cd_r[p] != '0) begin
                cdNext_s[p] = cd_r[p] - CD_W'(1);
            end else begin
                cdNext_s[p] = cd_r[p];
            end
        end

        if (anyGrant_s && both_s) begin
            lastServedNext_s = ~grant_s;
        end else begin
            lastServedNext_s = lastServed_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r       <= 2'b00;
            pend_r       <= 2'b00;
            lastServed_r <= 1'b0;
            o_wrEn       <= 1'b0;
            o_wrIdx      <= 7'd0;
            o_wrVal      <= 2'd0;
            o_reject     <= 1'b0;
            o_activeA    <= 2'd0;
            o_activeB    <= 2'd0;
            for (int p = 0; p < 2; p++) begin
                cd_r[p]    <= '0;
                valid_r[p] <= '0;
                fresh_r[p] <= '0;
                for (int s = 0; s < MAX_BOMBS; s++) begin
                    idx_r[p][s] <= 7'd0;
                end
            end
        end else begin
            prev_r       <= btn_s;
            pend_r       <= pendNext_s;
            lastServed_r <= lastServedNext_s;
            o_wrEn       <= pass_s;
            o_wrIdx      <= pass_s ? gIdx_s : 7'd0;
            o_wrVal      <= pass_s ? 2'd1 : 2'd0;
            o_reject     <= anyGrant_s & ~pass_s;
            o_activeA    <= popCount(validNext_s[0]);
            o_activeB    <= popCount(validNext_s[1]);
            for (int p = 0; p < 2; p++) begin
                cd_r[p]    <= cdNext_s[p];
                valid_r[p] <= validNext_s[p];
                fresh_r[p] <= freshNext_s[p];
                for (int s = 0; s < MAX_BOMBS; s++) begin
                    idx_r[p][s] <= idxNext_s[p][s];
                end
            end
        end
    end

endmodule
